i2c_slave_top: RTL and testbench
================================

I2C_SLAVE_TOP -- requirements
Module: i2c_slave_top

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h24, the 7-bit I2C device address it responds to.
REQ-002 SHALL have parameter NUM_REGS, default 4, the number of implemented 8-bit registers at addresses 0..NUM_REGS-1.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, 10 MHz nominal; all logic on its rising edge.
REQ-004 SHALL have port button_0, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port scl, input, 1 bit: I2C clock from an external master; no clock stretching.
REQ-006 SHALL have port sda, inout, 1 bit: I2C data, open-drain, driven only 0 or Z and never 1; external pull-up.

Function
REQ-007 SHALL pass scl and sda through 2-flop synchronizers and detect SCL rise/fall edges from the synchronized values.
REQ-008 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both are detected in any state.
REQ-009 SHALL use FSM states IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_DATA, RD_ACK.
REQ-010 SHALL, on START (including repeated START), go to DEV_ADDR and clear the bit counter; on STOP, go to IDLE and release sda.
REQ-011 SHALL sample SDA on SCL rising edges, MSB first, with 8 bits per byte; the 9th clock is the ACK slot.
REQ-012 SHALL ACK (drive sda low for the 9th SCL high phase) when the 7-bit address equals SLAVE_ADDR; on mismatch it SHALL NACK (leave sda Z), go to IDLE, and ignore traffic until the next START.
REQ-013 SHALL, on address match with R/W=0, receive the next byte as the register pointer, ACK it, then treat each following byte as write data.
REQ-014 SHALL ACK each write-data byte, store it at the pointer if the pointer < NUM_REGS (otherwise discard), and increment the pointer.
REQ-015 SHALL, on address match with R/W=1, shift out reg[pointer] MSB first, returning 8'h00 when the pointer >= NUM_REGS.
REQ-016 SHALL, after each read byte, sample the master ACK: on ACK, increment the pointer and send the next byte; on NACK, release sda and wait for STOP/START.
REQ-017 SHALL increment the pointer as an 8-bit value wrapping 8'hFF to 8'h00, and SHALL retain the pointer across a repeated START.
REQ-018 SHALL change sda only after a synchronized SCL falling edge, within 3 clk cycles, and hold it through the following SCL high phase.
REQ-019 SHALL operate at 400 kHz Fast-mode (SCL high >= 600 ns) with a 10 MHz clk.
REQ-020 SHALL handle a START or STOP arriving mid-byte by abandoning that byte with no register write.

Reset
REQ-021 SHALL, while button_0=1, asynchronously force the FSM to IDLE, sda released (Z), all registers to 8'h00, pointer to 8'h00, bit counter to 0 and synchronizers to 1.
REQ-022 SHALL, if reset occurs mid-transaction, resume only at the next START after reset release.

Structure
REQ-023 SHALL place the FSM state enum, SLAVE_ADDR default and NUM_REGS default in shared package i2c_slave_pkg.
REQ-024 SHALL contain one sub-module, i2c_slave_core (synchronizers, START/STOP detection, FSM, sda drive), exposing a write strobe, pointer, write data and read data to a register file in the top level.

Verification
REQ-025 SHALL verify that, after reset, reading device 0x24 register 0x8F returns 8'h00, and the address and pointer are ACKed.
REQ-026 SHALL verify that writing 0x24 reg 0x03 = 8'h7B and then reg 0x02 = 8'h3A, then reading reg 0x03, returns 8'h7B.
REQ-027 SHALL verify that a two-byte write of 8'hCB then 8'h04 to reg 0x00, followed by a two-byte read from reg 0x00, returns 8'hCB and 8'h04 (pointer auto-increment).
REQ-028 SHALL verify that writing to address 7'h18 (8'h98 truncated) and reading 7'h23 both get a NACK on the address byte, leave sda Z, and leave registers unchanged.
REQ-029 SHALL verify that a two-byte read from 0x24 reg 0x02 returns 8'h3A then 8'h7B, with the master NACK releasing sda and a STOP returning the FSM to IDLE.
REQ-030 SHALL verify that asserting button_0 mid-write-byte clears all registers to 8'h00 and releases sda, and that the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C register slave.
//   SLAVE_ADDR_DEF : default 7-bit device address
//   NUM_REGS_DEF   : default number of 8-bit registers
//   state_t        : protocol FSM states
package i2c_slave_pkg;

  localparam logic [6:0]  SLAVE_ADDR_DEF = 7'h24;
  localparam int unsigned NUM_REGS_DEF   = 4;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    ACK_DEV,
    REG_ADDR,
    ACK_REG,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    RD_ACK
  } state_t;

endpackage

// File: rtl/i2c_slave_core.sv
// I2C slave protocol engine: input synchronizers, START/STOP detection,
// byte FSM and open-drain sda enable. Register storage lives outside.
//   i_clk, i_rst : system clock, async active-high reset
//   i_scl, i_sda : raw bus inputs
//   o_sda_oe     : 1 = pull sda low, 0 = release
//   o_wr_en      : one-cycle write strobe for o_wdata at o_ptr
//   o_ptr        : current register pointer
//   i_rdata      : register contents at o_ptr (8'h00 if unimplemented)
module i2c_slave_core
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_en,
  output logic [7:0] o_ptr,
  output logic [7:0] o_wdata,
  input  logic [7:0] i_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_scl_sync;
  logic [1:0]  r_sda_sync;
  logic        r_scl_prev;
  logic        r_sda_prev;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_tx;
  logic [7:0]  r_ptr;
  logic        r_mnack;

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_byte_done, w_addr_match;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  assign w_scl        = r_scl_sync[1];
  assign w_sda        = r_sda_sync[1];
  assign w_scl_rise   = w_scl & ~r_scl_prev;
  assign w_scl_fall   = ~w_scl & r_scl_prev;
  assign w_start      = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop       = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_byte_done  = (r_bit_cnt == 4'd8);
  assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: every drive-changing transition happens on an SCL fall,
  // so the combinational sda enable only moves while SCL is low.
  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = DEV_ADDR;
    end else if (w_stop) begin
      w_next = IDLE;
    end else if (w_scl_fall) begin
      case (r_state)
        DEV_ADDR: if (w_byte_done) w_next = w_addr_match ? ACK_DEV : IDLE;
        ACK_DEV:  w_next = r_shift[0] ? RD_DATA : REG_ADDR;
        REG_ADDR: if (w_byte_done) w_next = ACK_REG;
        ACK_REG:  w_next = WR_DATA;
        WR_DATA:  if (w_byte_done) w_next = ACK_WR;
        ACK_WR:   w_next = WR_DATA;
        RD_DATA:  if (w_byte_done) w_next = RD_ACK;
        RD_ACK:   w_next = r_mnack ? IDLE : RD_DATA;
        default:  w_next = r_state;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_sda_oe = 1'b0;
    case (r_state)
      ACK_DEV, ACK_REG, ACK_WR: o_sda_oe = 1'b1;
      RD_DATA:                  o_sda_oe = ~r_tx[7];
      default:                  o_sda_oe = 1'b0;
    endcase
    o_wr_en = (r_state == WR_DATA) && w_scl_fall && w_byte_done;
  end

  assign o_ptr   = r_ptr;
  assign o_wdata = r_shift;

  // Datapath: shift/count on SCL rise, byte completion on SCL fall.
  // The read pointer advances on the rise that samples the master ACK so
  // that i_rdata already reflects the next register at the following fall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_ptr     <= '0;
      r_mnack   <= 1'b1;
    end else if (w_start || w_stop) begin
      r_bit_cnt <= '0;
    end else if (w_scl_rise) begin
      case (r_state)
        DEV_ADDR, REG_ADDR, WR_DATA: begin
          r_shift   <= {r_shift[6:0], w_sda};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        RD_DATA: r_bit_cnt <= r_bit_cnt + 4'd1;
        RD_ACK: begin
          r_mnack <= w_sda;
          if (!w_sda) r_ptr <= r_ptr + 8'd1;
        end
        default: ;
      endcase
    end else if (w_scl_fall) begin
      case (r_state)
        REG_ADDR: if (w_byte_done) r_ptr <= r_shift;
        WR_DATA:  if (w_byte_done) r_ptr <= r_ptr + 8'd1;
        ACK_DEV: begin
          r_bit_cnt <= '0;
          if (r_shift[0]) r_tx <= i_rdata;
        end
        ACK_REG, ACK_WR: r_bit_cnt <= '0;
        RD_DATA: if (!w_byte_done) r_tx <= {r_tx[6:0], 1'b0};
        RD_ACK: begin
          r_bit_cnt <= '0;
          r_tx      <= i_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/i2c_slave_top.sv
// I2C register slave top level: protocol core plus NUM_REGS x 8-bit
// register file; unimplemented addresses read 8'h00 and drop writes.
//   clk      : 10 MHz system clock
//   button_0 : async active-high reset
//   scl      : I2C clock from master
//   sda      : open-drain I2C data (driven 0 or Z only)
module i2c_slave_top
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = SLAVE_ADDR_DEF,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF
) (
  input  logic clk,
  input  logic button_0,
  input  logic scl,
  inout  wire  sda
);

  localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic            w_sda_oe;
  logic            w_wr_en;
  logic [7:0]      w_ptr;
  logic [7:0]      w_wdata;
  logic [7:0]      w_rdata;
  logic            w_in_range;
  logic [IDXW-1:0] w_idx;
  logic [7:0]      r_regs [NUM_REGS];

  assign sda = w_sda_oe ? 1'b0 : 1'bz;

  i2c_slave_core #(.SLAVE_ADDR(SLAVE_ADDR)) u_core (
    .i_clk    (clk),
    .i_rst    (button_0),
    .i_scl    (scl),
    .i_sda    (sda),
    .o_sda_oe (w_sda_oe),
    .o_wr_en  (w_wr_en),
    .o_ptr    (w_ptr),
    .o_wdata  (w_wdata),
    .i_rdata  (w_rdata)
  );

  assign w_in_range = (32'(w_ptr) < NUM_REGS);
  assign w_idx      = w_ptr[IDXW-1:0];
  assign w_rdata    = w_in_range ? r_regs[w_idx] : '0;

  always_ff @(posedge clk or posedge button_0) begin
    if (button_0) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en && w_in_range) begin
      r_regs[w_idx] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_i2c_slave_top.sv
`timescale 1ns/1ps
module tb_i2c_slave_top;
  import i2c_slave_pkg::*;

  localparam int Q = 625;  // quarter of a 2.5 us (400 kHz) SCL period

  logic clk = 1'b0;
  logic button_0;
  logic scl;
  logic m_sda_low;
  wire  sda_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_top #(.SLAVE_ADDR(7'h24), .NUM_REGS(4)) dut (
    .clk      (clk),
    .button_0 (button_0),
    .scl      (scl),
    .sda      (sda_bus)
  );

  always #50 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: register array and pointer, updated per transaction.
  logic [7:0] model_regs [4];
  logic [7:0] model_ptr;
  logic [7:0] wq [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd();
    return (model_ptr < 8'd4) ? model_regs[model_ptr[1:0]] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    model_ptr = 8'h00;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b1; #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; #Q;
    scl = 1'b1;     #(2*Q);
    scl = 1'b0;     #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    b = sda_bus;      #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(~mack);
  endtask

  task automatic m_write(input logic [6:0] dev, input logic [7:0] p);
    logic ack;
    logic match;
    match = (dev == 7'h24);
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    chk("wr_addr_ack", {7'b0, ack}, {7'b0, match});
    write_byte(p, ack);
    chk("wr_ptr_ack", {7'b0, ack}, {7'b0, match});
    if (match) model_ptr = p;
    foreach (wq[i]) begin
      write_byte(wq[i], ack);
      chk("wr_data_ack", {7'b0, ack}, {7'b0, match});
      if (match) begin
        if (model_ptr < 8'd4) model_regs[model_ptr[1:0]] = wq[i];
        model_ptr = model_ptr + 8'd1;
      end
    end
    i2c_stop();
  endtask

  task automatic m_set_read(input logic [6:0] dev, input logic [7:0] p, input int n);
    logic ack;
    logic match;
    logic [7:0] d;
    match = (dev == 7'h24);
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    chk("rdset_addr_ack", {7'b0, ack}, {7'b0, match});
    write_byte(p, ack);
    chk("rdset_ptr_ack", {7'b0, ack}, {7'b0, match});
    if (match) model_ptr = p;
    i2c_start();
    write_byte({dev, 1'b1}, ack);
    chk("rd_addr_ack", {7'b0, ack}, {7'b0, match});
    for (int i = 0; i < n; i++) begin
      read_byte(d, i != n - 1);
      chk("rd_data", d, match ? model_rd() : 8'hFF);
      if (match && i != n - 1) model_ptr = model_ptr + 8'd1;
    end
    chk("rd_release", {7'b0, sda_bus}, 8'h01);
    i2c_stop();
  endtask

  initial begin
    logic ack;
    logic [6:0] dev;
    logic [7:0] p;
    int n;

    scl = 1'b1;
    m_sda_low = 1'b0;
    button_0 = 1'b1;
    model_clear();
    #500;
    button_0 = 1'b0;
    #(2*Q);
    chk("reset_sda", {7'b0, sda_bus}, 8'h01);
    chk("reset_state", 8'(dut.u_core.r_state), 8'(IDLE));

    // Out-of-range pointer reads as zero
    m_set_read(7'h24, 8'h8F, 1);

    // Two writes then read back the first
    wq = '{8'h7B}; m_write(7'h24, 8'h03);
    wq = '{8'h3A}; m_write(7'h24, 8'h02);
    m_set_read(7'h24, 8'h03, 1);

    // Burst write and burst read with auto-increment
    wq = '{8'hCB, 8'h04}; m_write(7'h24, 8'h00);
    m_set_read(7'h24, 8'h00, 2);

    // Foreign addresses are NACKed and leave registers untouched
    wq = '{8'h55}; m_write(7'h18, 8'h01);
    m_set_read(7'h23, 8'h00, 1);
    m_set_read(7'h24, 8'h00, 4);

    // Two-byte read, NACK releases, STOP returns to IDLE
    m_set_read(7'h24, 8'h02, 2);
    #(2*Q);
    chk("idle_after_stop", 8'(dut.u_core.r_state), 8'(IDLE));

    // Pointer wraps FF -> 00
    wq = '{8'h11, 8'h22}; m_write(7'h24, 8'hFF);
    m_set_read(7'h24, 8'h00, 2);

    // Randomised transactions
    repeat (14) begin
      dev = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h24;
      p   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      n   = $urandom_range(1, 3);
      wq.delete();
      repeat (n) wq.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) m_write(dev, p);
      else                           m_set_read(dev, p, n);
    end

    // Reset in the middle of a write data byte
    wq = '{8'hA5, 8'h5A, 8'hC3, 8'h3C}; m_write(7'h24, 8'h00);
    i2c_start();
    write_byte({7'h24, 1'b0}, ack);
    chk("rst_addr_ack", {7'b0, ack}, 8'h01);
    write_byte(8'h01, ack);
    chk("rst_ptr_ack", {7'b0, ack}, 8'h01);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    m_sda_low = 1'b0;
    button_0 = 1'b1;
    #300;
    chk("rst_sda_released", {7'b0, sda_bus}, 8'h01);
    button_0 = 1'b0;
    model_clear();
    #300;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    read_bit(ack);
    chk("rst_no_ack_until_start", {7'b0, ack}, 8'h01);
    i2c_stop();
    m_set_read(7'h24, 8'h00, 4);
    wq = '{8'h96}; m_write(7'h24, 8'h01);
    m_set_read(7'h24, 8'h01, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
